// File: rtl/tap_scan_sequencer.sv
// tap_scan_sequencer: command-driven TMS/TDI master for a 16-state TAP, with TDO capture and a TAP state mirror
// Ports:
//   clk, TRST                       clock (acts as TCK) and synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake; ready only while the TAP sits in Run_Test_Idle
//   cmd_op, cmd_len, cmd_data       00 RESET, 01 IR scan, 10 DR scan, 11 RUNTEST; length; TDI bits LSB first
//   rsp_valid, rsp_data             one-cycle completion pulse of a scan and the captured TDO bits
//   busy                            inverse of cmd_ready
//   TMS, TDI, TDO                   TAP pins; TDO is sampled on the edges ending shift cycles
//   tap_state                       predicted TAP state, same encoding as the TAP's state_obs
module tap_scan_sequencer #(
    parameter int IR_LEN  = 4,
    parameter int DR_MAX  = 32,
    parameter int RST_CYC = 5
) (
    input  logic                    clk,
    input  logic                    TRST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [$clog2(DR_MAX):0] cmd_len,
    input  logic [DR_MAX-1:0]       cmd_data,
    output logic                    rsp_valid,
    output logic [DR_MAX-1:0]       rsp_data,
    output logic                    busy,
    output logic                    TMS,
    output logic                    TDI,
    input  logic                    TDO,
    output logic [3:0]              tap_state
);
    localparam int IW = $clog2(DR_MAX);
    localparam int LW = IW + 1;
    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_RUN   = 2'b11;

    // Each state names the role of the cycle whose TMS/TDI it produces.
    typedef enum logic [3:0] {
        S_RST, S_RST0, S_IDLE, S_RUN, S_SEL_DR, S_SEL_IR,
        S_CAP, S_SH0, S_SHIFT, S_EXIT, S_UPD
    } state_t;

    state_t            state, state_n;
    logic [LW-1:0]     cnt, cnt_n, n_q, n_acc;
    logic [DR_MAX-1:0] data_q;
    logic              ir_q, accept, tms_n, tdi_n;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
        case (s)
            4'h0: tap_next = t ? 4'h0 : 4'h1;
            4'h1: tap_next = t ? 4'h2 : 4'h1;
            4'h2: tap_next = t ? 4'h9 : 4'h3;
            4'h3: tap_next = t ? 4'h5 : 4'h4;
            4'h4: tap_next = t ? 4'h5 : 4'h4;
            4'h5: tap_next = t ? 4'h8 : 4'h6;
            4'h6: tap_next = t ? 4'h7 : 4'h6;
            4'h7: tap_next = t ? 4'h8 : 4'h4;
            4'h8: tap_next = t ? 4'h2 : 4'h1;
            4'h9: tap_next = t ? 4'h0 : 4'hA;
            4'hA: tap_next = t ? 4'hC : 4'hB;
            4'hB: tap_next = t ? 4'hC : 4'hB;
            4'hC: tap_next = t ? 4'hF : 4'hD;
            4'hD: tap_next = t ? 4'hE : 4'hD;
            4'hE: tap_next = t ? 4'hF : 4'hB;
            4'hF: tap_next = t ? 4'h2 : 4'h1;
        endcase
    endfunction

    // IR scans are fixed length, DR lengths are clamped to 1..DR_MAX, RUNTEST takes cmd_len as is.
    assign n_acc = cmd_op == OP_IR  ? LW'(IR_LEN) :
                   cmd_op == OP_RUN ? cmd_len :
                   cmd_len == '0    ? LW'(1) :
                   cmd_len > LW'(DR_MAX) ? LW'(DR_MAX) : cmd_len;

    always_comb begin
        accept  = cmd_valid && cmd_ready;
        state_n = state;
        case (state)
            S_RST:    state_n = cnt == LW'(RST_CYC - 1) ? S_RST0 : S_RST;
            S_RST0:   state_n = S_IDLE;
            S_IDLE:   state_n = !accept ? S_IDLE :
                                cmd_op == OP_RESET ? S_RST :
                                cmd_op == OP_RUN ? (cmd_len == '0 ? S_IDLE : S_RUN) : S_SEL_DR;
            S_RUN:    state_n = cnt == n_q - 1'b1 ? S_IDLE : S_RUN;
            S_SEL_DR: state_n = ir_q ? S_SEL_IR : S_CAP;
            S_SEL_IR: state_n = S_CAP;
            S_CAP:    state_n = S_SH0;
            S_SH0:    state_n = S_SHIFT;
            S_SHIFT:  state_n = cnt == n_q - 1'b1 ? S_EXIT : S_SHIFT;
            S_EXIT:   state_n = S_UPD;
            S_UPD:    state_n = S_IDLE;
            default:  state_n = S_RST;
        endcase
        // cnt counts cycles spent in the current state; it restarts on every state change.
        cnt_n = state_n == state ? cnt + 1'b1 : '0;
        tms_n = state_n inside {S_RST, S_SEL_DR, S_SEL_IR, S_EXIT} ||
                (state_n == S_SHIFT && cnt_n == n_q - 1'b1);
        tdi_n = state_n == S_SHIFT && data_q[cnt_n[IW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (TRST) begin
            state     <= S_RST;
            cnt       <= '0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            tap_state <= 4'h0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            TMS       <= tms_n;
            TDI       <= tdi_n;
            cmd_ready <= state_n == S_IDLE;
            busy      <= state_n != S_IDLE;
            rsp_valid <= state == S_UPD;
            // The mirror follows the TMS value the TAP consumes at this edge.
            tap_state <= tap_next(tap_state, TMS);
            if (accept && (cmd_op == OP_IR || cmd_op == OP_DR))
                rsp_data <= '0;
            else if (state == S_SHIFT)
                rsp_data[cnt[IW-1:0]] <= TDO;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ir_q   <= cmd_op == OP_IR;
            n_q    <= n_acc;
            data_q <= cmd_data;
        end
    end
endmodule

// File: tb/tb_tap_scan_sequencer.sv
// tb_tap_scan_sequencer: randomized self-checking bench with a behavioural TAP and per-command expected streams
module tb_tap_scan_sequencer;
    logic        clk = 1'b0;
    logic        TRST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_ready, rsp_valid, busy, TMS, TDI, TDO;
    logic [31:0] rsp_data;
    logic [3:0]  tap_state;
    logic [3:0]  tap_obs;
    logic [4:0]  sh_idx;
    logic [31:0] tdo_pat = 32'd0;
    logic [31:0] last_rsp = 32'd0;
    logic        loopback = 1'b0;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic        e_tms[$];
    logic        e_sh[$];
    logic        e_tdi[$];
    logic [3:0]  nx0 [16] = '{4'h1, 4'h1, 4'h3, 4'h4, 4'h4, 4'h6, 4'h6, 4'h4,
                              4'h1, 4'hA, 4'hB, 4'hB, 4'hD, 4'hD, 4'hB, 4'h1};
    logic [3:0]  nx1 [16] = '{4'h0, 4'h2, 4'h9, 4'h5, 4'h5, 4'h8, 4'h7, 4'h8,
                              4'h2, 4'h0, 4'hC, 4'hC, 4'hF, 4'hE, 4'hF, 4'h2};

    always #5 clk = ~clk;

    tap_scan_sequencer dut (
        .clk       (clk),
        .TRST      (TRST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .tap_state (tap_state)
    );

    // Behavioural TAP: graph tables, shift-cycle index and a TDO source.
    always @(posedge clk) begin
        tap_obs <= TRST ? 4'h0 : (TMS ? nx1[tap_obs] : nx0[tap_obs]);
        sh_idx  <= (tap_obs == 4'h4 || tap_obs == 4'hB) ? sh_idx + 5'd1 : 5'd0;
    end
    assign TDO = loopback ? TDI : tdo_pat[sh_idx];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (mon_en) chk("tap_state", 32'(tap_state), 32'(tap_obs));

    function automatic void push(input logic t, input logic s, input logic d);
        e_tms.push_back(t);
        e_sh.push_back(s);
        e_tdi.push_back(d);
    endfunction

    task automatic build(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         output logic [31:0] exp_rsp, output bit scan);
        int n;
        logic [63:0] m;
        e_tms.delete();
        e_sh.delete();
        e_tdi.delete();
        scan = op == 2'b01 || op == 2'b10;
        n = op == 2'b01 ? 4 : (len == 6'd0 ? 1 : (len > 6'd32 ? 32 : int'(len)));
        if (op == 2'b00) begin
            repeat (5) push(1'b1, 1'b0, 1'b0);
            push(1'b0, 1'b0, 1'b0);
        end else if (op == 2'b11) begin
            repeat (int'(len)) push(1'b0, 1'b0, 1'b0);
        end else begin
            push(1'b1, 1'b0, 1'b0);
            if (op == 2'b01) push(1'b1, 1'b0, 1'b0);
            push(1'b0, 1'b0, 1'b0);
            push(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < n; i++) push(i == n - 1, 1'b1, data[i]);
            push(1'b1, 1'b0, 1'b0);
            push(1'b0, 1'b0, 1'b0);
        end
        m = (64'd1 << n) - 64'd1;
        exp_rsp = scan ? ((loopback ? data : tdo_pat) & m[31:0]) : last_rsp;
    endtask

    // Starts in the first cycle after accept (or after TRST) and ends in the cycle ready returns.
    task automatic follow(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        logic [31:0] exp_rsp;
        bit scan;
        build(op, len, data, exp_rsp, scan);
        foreach (e_tms[i]) begin
            chk("tms", 32'(TMS), 32'(e_tms[i]));
            if (e_sh[i]) chk("tdi", 32'(TDI), 32'(e_tdi[i]));
            chk("busy_ready", 32'({busy, cmd_ready}), 32'd2);
            chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("ready_end", 32'({busy, cmd_ready}), 32'd1);
        chk("rsp_valid_end", 32'(rsp_valid), 32'(scan));
        chk("rsp_data", rsp_data, exp_rsp);
        chk("tap_rti", 32'(tap_obs), 32'd1);
        last_rsp = exp_rsp;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data, input int gap);
        int w = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
            chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        end
        while (!cmd_ready && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_len = len;
        cmd_data = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_len = 6'($urandom);
        cmd_data = $urandom;
        follow(op, len, data);
    endtask

    task automatic reset_chk();
        chk("rst_tdi", 32'(TDI), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_tap_state", 32'(tap_state), 32'd0);
        last_rsp = 32'd0;
        follow(2'b00, 6'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        @(posedge clk);
        #1;
        TRST = 1'b0;
        mon_en = 1'b1;
        reset_chk();
        loopback = 1'b1;
        run_cmd(2'b10, 6'd8, 32'h000000A5, 0);
        loopback = 1'b0;
        tdo_pat = 32'hFFFFFFFF;
        run_cmd(2'b01, 6'd0, 32'h0000000B, 1);
        tdo_pat = $urandom;
        run_cmd(2'b10, 6'd0, $urandom, 0);
        tdo_pat = $urandom;
        run_cmd(2'b10, 6'd40, $urandom, 2);
        loopback = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_len = 6'd16;
        cmd_data = $urandom;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("abort_in_shift", 32'(tap_obs), 32'd4);
        TRST = 1'b1;
        @(posedge clk);
        #1;
        TRST = 1'b0;
        reset_chk();
        loopback = 1'b0;
        tdo_pat = $urandom;
        d = $urandom;
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        cmd_len = 6'd3;
        @(posedge clk);
        #1;
        cmd_op = 2'b10;
        cmd_len = 6'd12;
        cmd_data = d;
        follow(2'b11, 6'd3, 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        follow(2'b10, 6'd12, d);
        repeat (40) begin
            loopback = 1'($urandom_range(0, 1));
            tdo_pat = $urandom;
            run_cmd(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
